// File: rtl/pwm_fader_pkg.sv
// pwm_fader_pkg
//   Shared definitions for the pwm_fader block.
//   chan_w(): width of the channel-select field. It never returns less
//   than 1, so a single-channel build still has a legal select port.
package pwm_fader_pkg;

    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage : pwm_fader_pkg

// File: rtl/pwm_fader_chan.sv
// pwm_fader_chan
//   One PWM channel. It holds the target, step and duty registers, the
//   saturating fade arithmetic and the registered PWM compare.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     cnt          shared period counter
//     wrap         high in the last cycle of the period (cnt == all ones)
//     wr_en        load wr_target / wr_step into this channel
//     wr_target    new target duty
//     wr_step      new fade step (0 = jump straight to target)
//     pwm_out      registered (cnt < duty)
//     busy         duty has not yet reached target
module pwm_fader_chan #(
    parameter int WIDTH  = 16,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  cnt,
    input  logic              wrap,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_target,
    input  logic [STEP_W-1:0] wr_step,
    output logic              pwm_out,
    output logic              busy
);

    // One bit wider than the wider operand, so the sum cannot wrap and a
    // borrow out of the difference is visible.
    localparam int EXT_W = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    logic [WIDTH-1:0]  duty;
    logic [WIDTH-1:0]  target;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  duty_next;

    logic [EXT_W-1:0] duty_x;
    logic [EXT_W-1:0] target_x;
    logic [EXT_W-1:0] step_x;
    logic [EXT_W-1:0] sum_x;
    logic [EXT_W-1:0] diff_x;

    assign duty_x   = EXT_W'(duty);
    assign target_x = EXT_W'(target);
    assign step_x   = EXT_W'(step);
    assign sum_x    = duty_x + step_x;
    assign diff_x   = duty_x - step_x;

    // Saturating move toward the target. A step larger than the duty
    // would underflow, so that case clamps to the target as well.
    always_comb begin
        // NOTE: defaulting every always_comb output first means no path
        // leaves it unassigned, so no latch is inferred.
        duty_next = duty;
        if (step == '0) begin
            duty_next = target;
        end else if (duty < target) begin
            duty_next = (sum_x >= target_x) ? target : sum_x[WIDTH-1:0];
        end else if (duty > target) begin
            duty_next = ((step_x > duty_x) || (diff_x <= target_x))
                        ? target : diff_x[WIDTH-1:0];
        end
    end

    // NOTE: these per-channel registers are few and control-critical, so
    // all of them reset; a reset mid-fade must leave no stale duty behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target  <= '0;
            step    <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (wr_en) begin
                target <= wr_target;
                step   <= wr_step;
            end
            // Duty changes only at the period boundary, so no period ever
            // sees a partly updated compare value.
            if (wrap) begin
                duty <= duty_next;
            end
            pwm_out <= (cnt < duty);
        end
    end

    assign busy = (duty != target);

endmodule : pwm_fader_chan

// File: rtl/pwm_fader.sv
// pwm_fader
//   N-channel PWM generator. Each channel fades linearly toward a
//   programmed target duty, one step per PWM period.
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     wr_valid      write request
//     wr_ready      write can be accepted (low only in the wrap cycle)
//     wr_chan       channel to write
//     wr_target     target duty
//     wr_step       fade step per period, 0 = jump immediately
//     wr_err        one-cycle pulse after an accepted write to a missing channel
//     pwm_out       PWM outputs, one per channel
//     busy          channel still fading toward its target
//     period_tick   high in the last cycle of every period
module pwm_fader
    import pwm_fader_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 16,
    parameter int STEP_W   = 8,
    localparam int CHAN_W  = chan_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CHAN_W-1:0]   wr_chan,
    input  logic [WIDTH-1:0]    wr_target,
    input  logic [STEP_W-1:0]   wr_step,
    output logic                wr_err,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CHANNELS-1:0] busy,
    output logic                period_tick
);

    // One wider than wr_chan, so the limit fits even when CHANNELS is a
    // power of two.
    localparam logic [CHAN_W:0] CHAN_LIM = (CHAN_W + 1)'(CHANNELS);

    logic [WIDTH-1:0] cnt;
    logic             wrap;
    logic             accept;
    logic             chan_bad;

    assign wrap        = (cnt == '1);
    assign period_tick = wrap;
    // Writes are held off in the wrap cycle, so a target load never
    // coincides with the fade update that reads the target.
    assign wr_ready    = !wrap;
    assign accept      = wr_valid && wr_ready;
    assign chan_bad    = ({1'b0, wr_chan} >= CHAN_LIM);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            wr_err <= 1'b0;
        end else begin
            cnt    <= cnt + WIDTH'(1);
            wr_err <= accept && chan_bad;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pwm_fader_chan #(
            .WIDTH  (WIDTH),
            .STEP_W (STEP_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .cnt       (cnt),
            .wrap      (wrap),
            .wr_en     (accept && (wr_chan == CHAN_W'(i))),
            .wr_target (wr_target),
            .wr_step   (wr_step),
            .pwm_out   (pwm_out[i]),
            .busy      (busy[i])
        );
    end

endmodule : pwm_fader

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader
//   Directed bench for pwm_fader at WIDTH=4, CHANNELS=3 (16-clock period).
//   The stimulus pushes the hand-computed result of each period into a
//   queue; the monitor counts pwm_out high clocks over each period window
//   and compares them, together with busy, against the popped entry.
module tb_pwm_fader;

    localparam int CHANNELS = 3;
    localparam int WIDTH    = 4;
    localparam int STEP_W   = 8;
    localparam int CHAN_W   = 2;

    typedef struct packed {
        logic [2:0][4:0] cnt;      // high clocks per channel in the period
        logic [2:0]      bmid;     // busy sampled at cnt=8
        logic [2:0]      bend;     // busy sampled at cnt=0 of the next period
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                wr_valid;
    logic                wr_ready;
    logic [CHAN_W-1:0]   wr_chan;
    logic [WIDTH-1:0]    wr_target;
    logic [STEP_W-1:0]   wr_step;
    logic                wr_err;
    logic [CHANNELS-1:0] pwm_out;
    logic [CHANNELS-1:0] busy;
    logic                period_tick;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   err_q[$];

    // Bench-side period position, cleared by the same reset.
    logic [3:0] tb_cnt;

    pwm_fader #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH),
        .STEP_W   (STEP_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_chan     (wr_chan),
        .wr_target   (wr_target),
        .wr_step     (wr_step),
        .wr_err      (wr_err),
        .pwm_out     (pwm_out),
        .busy        (busy),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= '0;
        else        tb_cnt <= tb_cnt + 4'd1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int         acc [3];
    bit         primed;
    bit         acc_pred;
    logic [2:0] bmid_s;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) acc[i] = 0;
            primed   = 1'b0;
            acc_pred = 1'b0;
        end else begin
            bit   exp_err;
            exp_t e;
            check("period_tick", int'(period_tick), int'(tb_cnt == 4'd15));
            check("wr_ready", int'(wr_ready), int'(tb_cnt != 4'd15));
            exp_err = 1'b0;
            if (acc_pred) begin
                if (err_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_err_queue actual=empty expected=entry");
                end else begin
                    exp_err = err_q.pop_front();
                end
            end
            check("wr_err", int'(wr_err), int'(exp_err));
            acc_pred = wr_valid && (tb_cnt != 4'd15);
            if (tb_cnt == 4'd8) bmid_s = busy;
            for (int i = 0; i < 3; i++) acc[i] += int'(pwm_out[i]);
            if (tb_cnt == 4'd0) begin
                if (primed) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL period_queue actual=empty expected=entry");
                    end else begin
                        e = exp_q.pop_front();
                        check("high_clocks_ch0", acc[0], int'(e.cnt[0]));
                        check("high_clocks_ch1", acc[1], int'(e.cnt[1]));
                        check("high_clocks_ch2", acc[2], int'(e.cnt[2]));
                        check("busy_mid", int'(bmid_s), int'(e.bmid));
                        check("busy_end", int'(busy), int'(e.bend));
                    end
                end
                for (int i = 0; i < 3; i++) acc[i] = 0;
                primed = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Advances to the cycle where the period position equals k (at least
    // one clock); returns 1 ns after that clock edge.
    task automatic wait_cnt(input int k);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((int'(tb_cnt) != k) && (n < 64));
        if (n >= 64) begin
            checks++; errors++;
            $display("FAIL wait_cnt_timeout actual=%0d expected=%0d", tb_cnt, k);
        end
    endtask

    task automatic push_exp(input int c0, input int c1, input int c2,
                            input logic [2:0] bm, input logic [2:0] be);
        exp_t e;
        e.cnt[0] = 5'(c0);
        e.cnt[1] = 5'(c1);
        e.cnt[2] = 5'(c2);
        e.bmid   = bm;
        e.bend   = be;
        exp_q.push_back(e);
    endtask

    // Called at the first cycle of a period; returns at the first cycle of
    // the next one. Optionally issues a write at period position k.
    task automatic run_period(input int c0, input int c1, input int c2,
                              input logic [2:0] bm, input logic [2:0] be,
                              input bit do_wr, input int k,
                              input int ch, input int tg, input int st);
        push_exp(c0, c1, c2, bm, be);
        if (do_wr) begin
            wait_cnt(k);
            wr_valid  = 1'b1;
            wr_chan   = CHAN_W'(ch);
            wr_target = WIDTH'(tg);
            wr_step   = STEP_W'(st);
            err_q.push_back(ch >= CHANNELS);
            @(posedge clk);
            #1;
            wr_valid = 1'b0;
        end
        wait_cnt(0);
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_chan   = '0;
        wr_target = '0;
        wr_step   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pwm_out", int'(pwm_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_wr_err", int'(wr_err), 0);
        check("reset_period_tick", int'(period_tick), 0);
        rst_n = 1'b1;

        // Idle: three full periods of nothing.
        repeat (3) run_period(0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);

        // ch0 jump to 8 written at cnt=3.
        run_period(0, 0, 0, 3'b001, 3'b000, 1, 3, 0, 8, 0);
        run_period(8, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);

        // ch1 fade up to 15 in steps of 4: 4, 8, 12, 15.
        run_period(8,  0, 0, 3'b010, 3'b010, 1, 2, 1, 15, 4);
        run_period(8,  4, 0, 3'b010, 3'b010, 0, 0, 0, 0, 0);
        run_period(8,  8, 0, 3'b010, 3'b010, 0, 0, 0, 0, 0);
        run_period(8, 12, 0, 3'b010, 3'b000, 0, 0, 0, 0, 0);
        run_period(8, 15, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);

        // ch1 fade down to 1 in steps of 5: 10, 5, 1.
        run_period(8, 15, 0, 3'b010, 3'b010, 1, 2, 1, 1, 5);
        run_period(8, 10, 0, 3'b010, 3'b010, 0, 0, 0, 0, 0);
        run_period(8,  5, 0, 3'b010, 3'b000, 0, 0, 0, 0, 0);

        // wr_valid raised in the wrap cycle: accepted at cnt=0 of the next
        // period, so ch2's new duty appears one period later.
        push_exp(8, 1, 0, 3'b000, 3'b000);
        wait_cnt(15);
        wr_valid  = 1'b1;
        wr_chan   = 2'd2;
        wr_target = 4'd5;
        wr_step   = 8'd0;
        err_q.push_back(1'b0);
        @(posedge clk);
        #1;
        push_exp(8, 1, 0, 3'b100, 3'b000);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wait_cnt(0);

        // Write to missing channel 3: wr_err pulse, nothing changes.
        run_period(8, 1, 5, 3'b000, 3'b000, 1, 2, 3, 9, 0);

        // ch0 fade down from 8 to 0 in steps of 2, then reset mid-fade.
        run_period(8, 1, 5, 3'b001, 3'b001, 1, 2, 0, 0, 2);
        push_exp(6, 1, 5, 3'b001, 3'b001);
        wait_cnt(5);
        rst_n = 1'b0;
        #1;
        check("midreset_pwm_out", int'(pwm_out), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_wr_err", int'(wr_err), 0);
        check("midreset_period_tick", int'(period_tick), 0);
        exp_q.delete();
        err_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All duties and targets must be back at zero.
        repeat (2) run_period(0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        check("period_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pwm_fader
